// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: default operand
// width, iteration counter width, the state encoding and a state helper.
package shift_add_mult_ctrl_pkg;

    localparam int NBits = 8;
    localparam int CNT_W = $clog2(NBits + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } mult_state_t;

    // States in which an operation is in flight and may be aborted.
    function automatic logic is_active(input mult_state_t s);
        return (s == LOAD) || (s == ADD) || (s == SHIFT);
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_iter_counter.sv
// Iteration counter: synchronous clear and increment, saturating at NBits,
// with a terminal-count flag raised while the count equals NBits.
module iter_counter #(
    parameter int NBits = 8,
    parameter int CNT_W = $clog2(NBits + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    assign terminal = (count == CNT_W'(NBits));

    // Count completed iterations; clear wins over increment, never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && !terminal) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of block evaluation order.
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for the iterative shift-add multiplier. Loads operands, runs
// NBits ADD/SHIFT iterations (add gated by the multiplier LSB), pulses done.
// Outputs are registered from the next state, except add_enable (gated by
// multiplier_lsb) and the abort term of clear_acc, which must act in the
// same cycle as their inputs.
module shift_add_mult_ctrl #(
    parameter int NBits = shift_add_mult_ctrl_pkg::NBits,
    parameter int CNT_W = $clog2(NBits + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             multiplier_lsb,
    output logic             ready,
    output logic             busy,
    output logic             load_operands,
    output logic             clear_acc,
    output logic             add_enable,
    output logic             shift_enable,
    output logic             done,
    output logic [CNT_W-1:0] iter_count
);

    import shift_add_mult_ctrl_pkg::*;

    mult_state_t state;
    mult_state_t state_nxt;
    logic        cnt_clear;
    logic        cnt_incr;
    logic        cnt_last;
    logic        cnt_term;

    // An aborted SHIFT does not count as a completed iteration.
    assign cnt_clear = (state == LOAD);
    assign cnt_incr  = (state == SHIFT) && !abort;
    assign cnt_last  = (iter_count == CNT_W'(NBits - 1));

    iter_counter #(
        .NBits (NBits),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .incr     (cnt_incr),
        .count    (iter_count),
        .terminal (cnt_term)
    );

    // Next-state decode; abort overrides normal flow while an operation runs.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? LOAD : IDLE;
            LOAD:    state_nxt = ADD;
            ADD:     state_nxt = SHIFT;
            // cnt_term also ends the run should the counter ever sit at NBits.
            SHIFT:   state_nxt = (cnt_last || cnt_term) ? DONE : ADD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && is_active(state)) begin
            state_nxt = IDLE;
        end
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            ready         <= 1'b1;
            busy          <= 1'b0;
            load_operands <= 1'b0;
            shift_enable  <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            ready         <= (state_nxt == IDLE);
            busy          <= is_active(state_nxt);
            load_operands <= (state_nxt == LOAD);
            shift_enable  <= (state_nxt == SHIFT);
            done          <= (state_nxt == DONE);
        end
    end

    assign add_enable = (state == ADD) & multiplier_lsb;
    assign clear_acc  = load_operands | (abort & busy);

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl with a small shift-add datapath
// model attached, so products can be checked against hand-computed values.
module tb_shift_add_mult_ctrl;

    localparam int NBITS = 8;
    localparam int CW    = $clog2(NBITS + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          multiplier_lsb;
    logic          ready;
    logic          busy;
    logic          load_operands;
    logic          clear_acc;
    logic          add_enable;
    logic          shift_enable;
    logic          done;
    logic [CW-1:0] iter_count;

    int n_checks = 0;
    int n_errors = 0;

    shift_add_mult_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .multiplier_lsb (multiplier_lsb),
        .ready          (ready),
        .busy           (busy),
        .load_operands  (load_operands),
        .clear_acc      (clear_acc),
        .add_enable     (add_enable),
        .shift_enable   (shift_enable),
        .done           (done),
        .iter_count     (iter_count)
    );

    always #5 clk = ~clk;

    // Datapath: p[15:8] accumulator, p[7:0] multiplier, carry out of the add.
    logic [7:0]  mcand_in = 8'h00;
    logic [7:0]  mplier_in = 8'h00;
    logic [7:0]  mcand_r = 8'h00;
    logic [15:0] p = 16'h0000;
    logic        carry = 1'b0;

    assign multiplier_lsb = p[0];

    always @(posedge clk) begin
        if (load_operands) begin
            p       <= {8'h00, mplier_in};
            mcand_r <= mcand_in;
            carry   <= 1'b0;
        end else if (clear_acc) begin
            p[15:8] <= 8'h00;
            carry   <= 1'b0;
        end else if (add_enable) begin
            {carry, p[15:8]} <= {1'b0, p[15:8]} + {1'b0, mcand_r};
        end else if (shift_enable) begin
            p     <= {carry, p[15:1]};
            carry <= 1'b0;
        end
    end

    // Per-operation observations; output vector is
    // {ready, busy, load_operands, clear_acc, add_enable, shift_enable, done}.
    logic [6:0]  out_log [64];
    int          cnt_log [64];
    int          n_load, n_shift, n_done, first_done, second_done;
    int          onehot_err, over_err;
    logic [7:0]  add_mask;
    logic [15:0] prod;
    logic        clr_at_abort;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge (cycle 0). start is high in cycle 0 and in
    // cycles 1..hold-1 and pulse_cyc; abort/rst are applied during one cycle.
    task automatic run_op(input logic [7:0] mc, input logic [7:0] mp,
                          input int hold, input int pulse_cyc,
                          input int abort_cyc, input int rst_cyc, input int ncyc);
        mcand_in = mc;
        mplier_in = mp;
        start = 1'b1;
        n_load = 0; n_shift = 0; n_done = 0; first_done = -1; second_done = -1;
        onehot_err = 0; over_err = 0; add_mask = 8'h00; prod = 16'hxxxx;
        clr_at_abort = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            out_log[c] = {ready, busy, load_operands, clear_acc, add_enable, shift_enable, done};
            cnt_log[c] = int'(iter_count);
            if (load_operands) n_load++;
            if (add_enable && n_shift < NBITS) add_mask[n_shift] = 1'b1;
            if (shift_enable) n_shift++;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_done = c;
                    prod = p;
                end else if (n_done == 2) begin
                    second_done = c;
                end
            end
            if (int'(ready) + int'(busy) + int'(done) != 1) onehot_err++;
            if (int'(iter_count) > NBITS) over_err++;
            start = (c < hold) || (c == pulse_cyc);
            rst   = (c != rst_cyc);
            abort = (c == abort_cyc);
            if (abort) begin
                #1;
                clr_at_abort = clear_acc;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst = 1'b1;
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (ready) seen = 1'b1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        check("drain_to_idle", int'(seen), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start = 1'b1;
        abort = 1'b0;

        // Reset held two cycles with start high: idle, nothing loaded.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_outputs", 32'({ready, busy, load_operands, clear_acc,
                                        add_enable, shift_enable, done}), 32'h40);
            check("reset_iter_count", int'(iter_count), 0);
        end
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // 0x0B * 0xA5 = 11 * 165 = 1815 = 0x0717; LSBs set at bits 0,2,5,7.
        run_op(8'h0B, 8'hA5, 1, -1, -1, -1, 22);
        check("a5_load_cycle1", 32'(out_log[1]), 32'h38);
        check("a5_first_add_count", cnt_log[2], 0);
        check("a5_add_mask", 32'(add_mask), 32'hA5);
        check("a5_shift_pulses", n_shift, 8);
        check("a5_load_pulses", n_load, 1);
        check("a5_done_cycle", first_done, 18);
        check("a5_done_outputs", 32'(out_log[18]), 32'h01);
        check("a5_done_count", cnt_log[18], 8);
        check("a5_ready_after", 32'(out_log[19]), 32'h40);
        check("a5_count_holds", cnt_log[20], 8);
        check("a5_product", 32'(prod), 32'h0717);
        check("a5_state_onehot", onehot_err, 0);
        check("a5_count_bound", over_err, 0);

        // Zero multiplier: no adds, same latency, product zero.
        run_op(8'h0B, 8'h00, 1, -1, -1, -1, 22);
        check("zero_add_mask", 32'(add_mask), 32'h00);
        check("zero_done_cycle", first_done, 18);
        check("zero_product", 32'(prod), 32'h0000);

        // All-ones multiplier: 11 * 255 = 2805 = 0x0AF5, add in every ADD.
        run_op(8'h0B, 8'hFF, 1, -1, -1, -1, 22);
        check("ff_add_mask", 32'(add_mask), 32'hFF);
        check("ff_done_cycle", first_done, 18);
        check("ff_product", 32'(prod), 32'h0AF5);

        // Abort in SHIFT of iteration 3 (cycle 9).
        run_op(8'h0B, 8'hA5, 1, -1, 9, -1, 25);
        check("abort_in_shift", 32'(out_log[9]), 32'h22);
        check("abort_clear_acc", 32'(clr_at_abort), 1);
        check("abort_idle_next", 32'(out_log[10]), 32'h40);
        check("abort_no_done", n_done, 0);

        // start held for 40 cycles: back-to-back runs, one IDLE between.
        run_op(8'h03, 8'h05, 40, -1, -1, -1, 42);
        check("b2b_first_done", first_done, 18);
        check("b2b_idle_gap", 32'(out_log[19]), 32'h40);
        check("b2b_second_load", 32'(out_log[20]), 32'h38);
        check("b2b_second_done", second_done, 37);
        check("b2b_done_count", n_done, 2);
        wait_idle();

        // start pulse while busy is not queued.
        run_op(8'h03, 8'h05, 1, 5, -1, -1, 22);
        check("ignored_start_loads", n_load, 1);
        check("ignored_start_done", first_done, 18);
        check("ignored_start_idle", 32'(out_log[20]), 32'h40);

        // Synchronous reset during cycle 10 (ADD of iteration 4).
        run_op(8'h0B, 8'hA5, 1, -1, -1, 10, 25);
        check("rst_mid_count_before", cnt_log[10], 4);
        check("rst_mid_outputs", 32'(out_log[11]), 32'h40);
        check("rst_mid_count", cnt_log[11], 0);
        check("rst_mid_no_done", n_done, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
